// File: rtl/sram_controller_pkg.sv
// Shared definitions for the cache-to-SRAM responder: state encoding and
// geometry constants.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam int unsigned BASE_ADDR_DFLT   = 1024;
  localparam int unsigned READ_HALVES      = 4;
  localparam int unsigned WRITE_HALVES     = 2;
  localparam int unsigned SRAM_ADDR_W_DFLT = 18;

endpackage

// File: rtl/sram_addr_map.sv
// Maps a memory-stage byte address onto SRAM halfword addresses: the 8-byte
// aligned line base for reads and the two halfwords of a word for writes.
module sram_addr_map
  import sram_controller_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DFLT,
  parameter int unsigned SRAM_ADDR_W = SRAM_ADDR_W_DFLT
) (
  input  logic [31:0]            address,
  output logic [SRAM_ADDR_W-1:0] line_base,
  output logic [SRAM_ADDR_W-1:0] word_lo,
  output logic [SRAM_ADDR_W-1:0] word_hi
);

  logic [31:0]            off;
  logic [SRAM_ADDR_W-2:0] word;
  logic                   unused_off_bits;

  // Bits of the offset above the SRAM range are dropped, so the map wraps.
  always_comb begin
    off       = address - 32'(BASE_ADDR);
    word      = off[SRAM_ADDR_W:2];
    line_base = {word[SRAM_ADDR_W-2:1], 2'b00};
    word_lo   = {word, 1'b0};
    word_hi   = {word, 1'b1};
  end

  assign unused_off_bits = ^{off[31:SRAM_ADDR_W+1], off[1:0]};

endmodule

// File: rtl/sram_controller.sv
// Responder for the memory-stage/SRAM link: 64-bit line reads as four halfword
// accesses, 32-bit write-through as two, on a 16-bit asynchronous SRAM.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DFLT,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned SRAM_ADDR_W = SRAM_ADDR_W_DFLT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [63:0]            read_data,
  output logic                   ready,
  inout  logic [15:0]            SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  localparam int unsigned     CW      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0]   C_LAST  = CW'(WAIT_CYCLES - 1);
  localparam logic [1:0]      RD_LAST = 2'(READ_HALVES - 1);
  localparam logic [1:0]      WR_LAST = 2'(WRITE_HALVES - 1);

  state_e                 state_q, state_d;
  logic [1:0]             h_q, h_d;
  logic [CW-1:0]          c_q, c_d;
  logic [SRAM_ADDR_W-1:0] base_q, base_d;
  logic [SRAM_ADDR_W-1:0] whi_q, whi_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [63:0]            rdata_q, rdata_d;
  logic                   we_n_q, we_n_d;
  logic                   oe_q, oe_d;
  logic [15:0]            dq_q, dq_d;

  logic [SRAM_ADDR_W-1:0] map_line, map_lo, map_hi;

  sram_addr_map #(
    .BASE_ADDR  (BASE_ADDR),
    .SRAM_ADDR_W(SRAM_ADDR_W)
  ) u_addr_map (
    .address  (address),
    .line_base(map_line),
    .word_lo  (map_lo),
    .word_hi  (map_hi)
  );

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    c_d     = c_q;
    base_d  = base_q;
    whi_d   = whi_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_en) begin
          state_d = ST_READ;
          h_d     = '0;
          c_d     = '0;
          base_d  = map_line;
          addr_d  = map_line;
        end else if (wr_en) begin
          state_d = ST_WRITE;
          h_d     = '0;
          c_d     = '0;
          whi_d   = map_hi;
          wdata_d = write_data;
          addr_d  = map_lo;
        end
      end
      ST_READ: begin
        if (c_q == C_LAST) begin
          rdata_d[{h_q, 4'b0000} +: 16] = SRAM_DQ;
          c_d = '0;
          if (h_q == RD_LAST) begin
            state_d = ST_DONE;
          end else begin
            h_d    = h_q + 2'd1;
            addr_d = base_q + SRAM_ADDR_W'(h_d);
          end
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      ST_WRITE: begin
        if (c_q == C_LAST) begin
          c_d = '0;
          if (h_q == WR_LAST) begin
            state_d = ST_DONE;
          end else begin
            h_d    = h_q + 2'd1;
            addr_d = whi_q;
          end
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (!rd_en && !wr_en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Pin controls are registered, so they are derived from the next state;
    // WE_N rises in the last cycle of each half only when there is slack.
    we_n_d = !(state_d == ST_WRITE && (WAIT_CYCLES == 1 || c_d != C_LAST));
    oe_d   = (state_d == ST_WRITE);
    dq_d   = h_d[0] ? wdata_d[31:16] : wdata_d[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      c_q     <= '0;
      base_q  <= '0;
      whi_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      dq_q    <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      c_q     <= c_d;
      base_q  <= base_d;
      whi_q   <= whi_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_n_q  <= we_n_d;
      oe_q    <= oe_d;
      dq_q    <= dq_d;
    end
  end

  assign ready     = (state_q == ST_IDLE && !rd_en && !wr_en) || (state_q == ST_DONE);
  assign read_data = rdata_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_DQ   = oe_q ? dq_q : 'z;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Responder side of the memory-stage/SRAM link: accepts read and write requests from the cache controller and drives the external 16-bit asynchronous SRAM chip (256K x 16).
- Reads return a full 64-bit cache line, fetched as four halfword accesses.
- Writes are write-through of one 32-bit word, done as two halfword accesses.
- Signals `ready` while idle or done, and holds it low while the access is in progress.

Parameters:
- BASE_ADDR, 1024: byte address of the first data-memory location; subtracted before mapping.
- WAIT_CYCLES, 1: clock cycles each halfword access is held on the SRAM pins (must be ≥1).
- SRAM_ADDR_W, 18: SRAM halfword address width.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- rd_en  input  1  line-read request; held until `ready` is high
- wr_en  input  1  word-write request; held until `ready` is high
- address  input  32  byte address from the memory stage
- write_data  input  32  word to store
- read_data  output  64  fetched line; halfword 0 is in [15:0]
- ready  output  1  high in IDLE with no request pending, and in DONE
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_ADDR  output  18  SRAM halfword address
- SRAM_WE_N  output  1  write enable, active low
- SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  tied low (always enabled, full halfword)

Behaviour:
- Reset (async, any time, including mid-access):
  - state IDLE, counters 0, read_data 0
  - SRAM_WE_N 1, SRAM_DQ high-Z, SRAM_ADDR 0
  - A partially written word may remain in the SRAM; this is not an error.
- Address map:
  - off = address − BASE_ADDR, 32-bit wrap-around subtraction
  - word = off[18:2]
  - Read line base = {word[16:1], 1'b0, 1'b0} as a halfword address, i.e. 8-byte aligned. Halfwords are line base + 0..3.
  - Write halfwords are {word, 0} (low) and {word, 1} (high).
  - Bits above 18 of off are ignored (the address wraps inside the SRAM).
- Request priority: if rd_en and wr_en are both high in IDLE, the read is taken; wr_en is ignored for that transaction.
- FSM states: IDLE, READ, WRITE, DONE.
  - IDLE: on rd_en → READ; on wr_en → WRITE. The address is decoded from live inputs, and address and write_data are latched on this edge.
  - READ: half index h = 0..3, per-half counter c = 0..WAIT_CYCLES−1.
    - SRAM_ADDR = base + h; WE_N = 1; DQ high-Z.
    - On the edge where c = WAIT_CYCLES−1, capture SRAM_DQ into read_data[16h+15:16h].
    - After h = 3 → DONE. Busy for exactly 4·WAIT_CYCLES cycles.
  - WRITE: h = 0..1.
    - SRAM_ADDR = word halfword h; DQ drives write_data[16h+15:16h].
    - WE_N = 0 except in the final cycle of each half when WAIT_CYCLES > 1. With WAIT_CYCLES = 1, WE_N = 0 for both cycles and the address changes while WE_N is low; the SRAM tolerates this at board timing.
    - After h = 1 → DONE. Busy for 2·WAIT_CYCLES cycles.
  - DONE: ready = 1, read_data stable. Leave to IDLE only when rd_en = 0 and wr_en = 0 (four-phase handshake). The requester must drop its request while in DONE.
- ready is combinational:
  - 1 when (IDLE and no request) or DONE
  - 0 in READ and WRITE, and in IDLE on the cycle a request arrives
- read_data holds its last value through writes and idle periods; it changes only during READ.
- Request lines changing during READ/WRITE are ignored; the latched address and data are used.
- SRAM_DQ is driven only in WRITE; it is high-Z in every other state and during reset.

Decomposition:
- Shared package:
  - state encoding (IDLE=2'b00, READ=2'b01, WRITE=2'b10, DONE=2'b11)
  - BASE_ADDR default
  - READ_HALVES = 4, WRITE_HALVES = 2
  - SRAM_ADDR_W
- Sub-module sram_addr_map (combinational): address → line-base and word halfword addresses. The FSM, counters, capture registers and tristate stay in sram_controller.

Test Plan:
- Reset mid-WRITE (assert rst at busy cycle 1) → WE_N = 1 and DQ = Z on the same cycle, read_data = 0, ready = 1 after rst drops.
- Write address = 1028, data = 0xDEADBEEF, WAIT_CYCLES = 1 → SRAM model halfword 2 = 0xBEEF, halfword 3 = 0xDEAD; ready low for 2 cycles, then high in DONE.
- Read address = 1036 (word 3) after SRAM halfwords 4..7 are preloaded with 0x1111, 0x2222, 0x3333, 0x4444 → SRAM_ADDR sequences 4, 5, 6, 7; read_data = 0x4444_3333_2222_1111; ready low for 4 cycles.
- Simultaneous rd_en = wr_en = 1 at address 1024 → read performed, no WE_N pulse, SRAM contents unchanged.
- WAIT_CYCLES = 3, read → ready low for 12 cycles, capture on cycles 3, 6, 9, 12; DQ never driven by the DUT.
- Request held high in DONE for 5 cycles → stays in DONE with ready = 1 and no new SRAM activity; after release, returns to IDLE and a new request is accepted next cycle.
